// File: rtl/matmul_sequencer.sv
// Index/address sequencer for C = A x B over operand RAMs, MAC and result RAM.
// Optional cycle counter built only when MATMUL_SEQ_PERF_EN is defined.
module matmul_sequencer #(
  parameter int MAX_N  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        size,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              size_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [15:0]       cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [4:0] MaxN = 5'(MAX_N);

  state_e            state_q, state_d;
  logic [3:0]        nm1_q, nm1_d;
  logic              err_q, err_d;
  logic [3:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic              s1_valid_q, s1_first_q, s1_last_q;
  logic [ADDR_W-1:0] s1_c_q;
  logic              s2_valid_q;
  logic [ADDR_W-1:0] s2_c_q;

  logic              size_ok, accept, k_wrap, j_wrap, i_wrap;
  logic [ADDR_W-1:0] n_w;

  assign size_ok = (size != 4'd0) && ({1'b0, size} <= MaxN);
  assign accept  = (state_q == S_IDLE) && start;
  assign n_w     = ADDR_W'(nm1_q) + ADDR_W'(1);
  assign k_wrap  = (k_q == nm1_q);
  assign j_wrap  = (j_q == nm1_q);
  assign i_wrap  = (i_q == nm1_q);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    nm1_d     = nm1_q;
    err_d     = err_q;
    busy      = (state_q != S_IDLE);
    rd_en     = (state_q == S_RUN) && !hold;
    done      = (state_q == S_DONE) && !hold;
    size_err  = done && err_q;
    mac_en    = s1_valid_q && !hold;
    mac_first = mac_en && s1_first_q;
    res_we    = s2_valid_q && !hold;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = !size_ok;
          nm1_d   = size_ok ? size - 4'd1 : nm1_q;
          state_d = size_ok ? S_RUN : S_DONE;
        end
      end
      S_RUN:   if (rd_en && k_wrap && j_wrap && i_wrap) state_d = S_DRAIN;
      // The final write issues in the cycle stage 1 empties; done follows it.
      S_DRAIN: if (!hold && !s1_valid_q) state_d = S_DONE;
      S_DONE:  if (!hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Running adders: a = i*N+k, b = k*N+j, c = i*N+j; all wrap to 0 after the last read.
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_base_d = a_base_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    if (accept && size_ok) begin
      i_d      = '0;
      j_d      = '0;
      k_d      = '0;
      a_base_d = '0;
      a_d      = '0;
      b_d      = '0;
      c_d      = '0;
    end else if (rd_en) begin
      if (!k_wrap) begin
        k_d = k_q + 4'd1;
        a_d = a_q + ADDR_W'(1);
        b_d = b_q + n_w;
      end else begin
        k_d = '0;
        c_d = c_q + ADDR_W'(1);
        if (!j_wrap) begin
          j_d = j_q + 4'd1;
          a_d = a_base_q;
          b_d = ADDR_W'(j_q) + ADDR_W'(1);
        end else begin
          j_d = '0;
          b_d = '0;
          if (!i_wrap) begin
            i_d      = i_q + 4'd1;
            a_base_d = a_base_q + n_w;
            a_d      = a_base_q + n_w;
          end else begin
            i_d      = '0;
            a_base_d = '0;
            a_d      = '0;
            c_d      = '0;
          end
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      nm1_q      <= '0;
      err_q      <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_base_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_c_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
    end else begin
      state_q  <= state_d;
      nm1_q    <= nm1_d;
      err_q    <= err_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_base_q <= a_base_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      if (!hold) begin
        s1_valid_q <= rd_en;
        s1_first_q <= (k_q == 4'd0);
        s1_last_q  <= k_wrap;
        s1_c_q     <= c_q;
        s2_valid_q <= s1_valid_q && s1_last_q;
        if (s1_valid_q && s1_last_q) s2_c_q <= s1_c_q;
      end
    end
  end

  assign a_addr   = a_q;
  assign b_addr   = b_q;
  assign res_addr = s2_c_q;

`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                            cnt_q <= '0;
    else if (accept)                    cnt_q <= '0;
    else if (busy && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: expected reads, MAC controls and
// writes are queued from an i/j/k model at start and popped as the DUT emits them.
module tb_matmul_sequencer;
  localparam int MAX_N  = 8;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, start, hold;
  logic [3:0]        size;
  logic              busy, done, size_err, rd_en, mac_en, mac_first, res_we;
  logic [ADDR_W-1:0] a_addr, b_addr, res_addr;
  logic [15:0]       cycle_count;

  always #5 clk = ~clk;

  matmul_sequencer #(.MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size), .hold(hold),
    .busy(busy), .done(done), .size_err(size_err), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .mac_en(mac_en), .mac_first(mac_first),
    .res_we(res_we), .res_addr(res_addr), .cycle_count(cycle_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {int a; int b; int cyc;} rd_t;
  typedef struct {int first; int cyc;}    mac_t;
  typedef struct {int addr; int cyc;}     wr_t;

  rd_t  rd_q[$];
  mac_t mac_q[$];
  wr_t  wr_q[$];
  rd_t  er;
  mac_t em;
  wr_t  ew;

  int real_cyc, log_cyc, exp_done, exp_err, done_cnt;
  bit running = 1'b0;

  // Logical cycle skips hold cycles, so queued cycle stamps are hold-free.
  always @(negedge clk) begin
    if (running) begin
      real_cyc++;
      if (!hold) log_cyc++;
      check("busy", busy, (real_cyc >= 1 && real_cyc <= exp_done));
      if (hold) check("hold_quiet", {rd_en, mac_en, res_we}, 0);
      if (rd_en) begin
        if (rd_q.size() == 0) check("rd_extra", 1, 0);
        else begin
          er = rd_q.pop_front();
          check("a_addr", a_addr, er.a);
          check("b_addr", b_addr, er.b);
          check("rd_cyc", log_cyc, er.cyc);
        end
      end
      if (mac_en) begin
        if (mac_q.size() == 0) check("mac_extra", 1, 0);
        else begin
          em = mac_q.pop_front();
          check("mac_first", mac_first, em.first);
          check("mac_cyc", log_cyc, em.cyc);
        end
      end
      if (res_we) begin
        if (wr_q.size() == 0) check("wr_extra", 1, 0);
        else begin
          ew = wr_q.pop_front();
          check("res_addr", res_addr, ew.addr);
          check("wr_cyc", log_cyc, ew.cyc);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_cyc", real_cyc, exp_done);
        check("size_err", size_err, exp_err);
      end else begin
        check("size_err_nodone", size_err, 0);
      end
    end
  end

  task automatic run(input int n, input int lo, input int hi, input int restart_at);
    int nh, t;
    bit bad;
    bad = (n == 0 || n > MAX_N);
    rd_q.delete();
    mac_q.delete();
    wr_q.delete();
    nh = (hi >= lo) ? hi - lo + 1 : 0;
    if (!bad) begin
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++)
          for (int k = 0; k < n; k++) begin
            t = 1 + (i * n + j) * n + k;
            rd_q.push_back('{a: i * n + k, b: k * n + j, cyc: t});
            mac_q.push_back('{first: (k == 0), cyc: t + 1});
            if (k == n - 1) wr_q.push_back('{addr: i * n + j, cyc: t + 2});
          end
    end
    exp_done = bad ? 1 : n * n * n + 3 + nh;
    exp_err  = bad;
    done_cnt = 0;
    @(posedge clk); #2;
    start    = 1'b1;
    size     = 4'(n);
    hold     = 1'b0;
    real_cyc = -1;
    log_cyc  = -1;
    running  = 1'b1;
    for (int c = 1; c <= exp_done + 20; c++) begin
      @(posedge clk); #2;
      if (done_cnt > 0 && real_cyc >= exp_done + 3) break;
      start = (c == restart_at);
      if (c == restart_at) size = 4'(n + 1);
      hold = (c >= lo && c <= hi);
    end
    running = 1'b0;
    start   = 1'b0;
    hold    = 1'b0;
    check("done_count", done_cnt, 1);
    check("rd_left", rd_q.size(), 0);
    check("mac_left", mac_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
  endtask

  task automatic reset_mid_run();
    @(posedge clk); #2;
    start = 1'b1;
    size  = 4'd4;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #2;
      start = 1'b0;
      rst   = (c == 5);
      if (c == 4) begin
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
      end
      if (c >= 6) begin
        @(negedge clk);
        check("rst_outs", {busy, done, size_err, rd_en, mac_en, mac_first, res_we,
                           a_addr, b_addr, res_addr}, 0);
        check("rst_cnt", cycle_count, 0);
      end
    end
  endtask

  initial begin
    int exp_cc;
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    size  = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {busy, done, size_err, rd_en, mac_en, mac_first, res_we,
                         a_addr, b_addr, res_addr}, 0);
    check("reset_cnt", cycle_count, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    run(2, 0, -1, 0);
    run(3, 5, 7, 0);
    run(0, 0, -1, 0);
    run(9, 0, -1, 0);
    run(1, 0, -1, 0);
    reset_mid_run();
    run(4, 0, -1, 0);
    run(2, 0, -1, 3);
    run(MAX_N, 100, 104, 0);

`ifdef MATMUL_SEQ_PERF_EN
    exp_cc = 13;
`else
    exp_cc = 0;
`endif
    run(2, 3, 4, 0);
    check("perf_after_done", cycle_count, exp_cc);
    repeat (5) @(posedge clk);
    #2;
    check("perf_holds", cycle_count, exp_cc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Sequences the matrix-multiply datapath once both operand matrices sit in the A and B operand RAMs. After a start pulse it walks the i/j/k index space for C = A×B, issuing operand-RAM read addresses and MAC accumulate controls. It issues result-RAM write strobes and signals completion back to the top-level control FSM. It sits between that control unit (start/done, matrix size) and the operand RAMs, MAC and result RAM.

## Interface
Parameters:
- MAX_N, 8: largest supported matrix dimension.
- ADDR_W, 8: RAM address width; must satisfy 2^ADDR_W ≥ MAX_N*MAX_N.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle request to begin a multiply; sampled only in IDLE.
- size  input  4  matrix dimension N; sampled with start.
- hold  input  1  freeze request, e.g. result RAM busy.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle completion pulse.
- size_err  output  1  high with done when size was 0 or > MAX_N.
- rd_en  output  1  operand RAM read enable; data returns 1 cycle later.
- a_addr  output  ADDR_W  A address, i*N+k (row-major).
- b_addr  output  ADDR_W  B address, k*N+j.
- mac_en  output  1  MAC consumes operand data this cycle.
- mac_first  output  1  with mac_en, load the product instead of accumulating (k==0).
- res_we  output  1  result RAM write strobe; the MAC result is valid.
- res_addr  output  ADDR_W  C address, i*N+j.
- cycle_count  output  16  performance counter; see Configuration.

## Operation
- States:
  - IDLE: start with 1 ≤ size ≤ MAX_N latches N, clears i/j/k and goes to RUN. start with a bad size goes to DONE with size_err set.
  - RUN: each non-hold cycle asserts rd_en with the current addresses, then advances k; on k wrap, j; on j wrap, i. Issuing the (N-1,N-1,N-1) read moves to DRAIN.
  - DRAIN: waits for the pipeline to empty, then goes to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Pipeline:
  - Stage 1 registers valid, first (k==0), last (k==N-1) and C index alongside each read.
  - Stage 1 drives mac_en and mac_first.
  - Stage 2 asserts res_we/res_addr one cycle after the mac_en with last=1.
- hold:
  - Freezes index counters, all pipeline stages and FSM state.
  - Forces rd_en, mac_en and res_we low.
  - Operand RAM outputs are stable because rd_en is low.
  - The control is at the same point when hold drops.
- Addresses are computed with running adders rather than multipliers. All addresses stay < N*N and never exceed ADDR_W bits.
- start while busy is ignored. size is not re-sampled during an operation.
- rst mid-operation returns to IDLE on the next edge and clears counters and pipeline valids. No res_we or done follows a reset.
- Reset value of every output is 0.

## Timing
- start accepted at edge 0; first rd_en in cycle 1.
- N³ read cycles without hold: last rd_en in cycle N³, its mac_en in N³+1.
- Final res_we in cycle N³+2; done in cycle N³+3.
- Each hold cycle delays all later events by exactly 1.
- One res_we every N mac_en cycles; N² writes in total, in res_addr order 0..N²-1.
- Size error: done and size_err in cycle 1; no rd_en, mac_en or res_we.
- N=1: rd_en in cycle 1 with mac_first=1; res_we in cycle 3; done in cycle 4.

## Configuration
- MATMUL_SEQ_PERF_EN defined:
  - cycle_count clears on start acceptance and increments every cycle while busy, including hold cycles.
  - It holds its value after done and saturates at 16'hFFFF.
- Not defined: cycle_count is constant 0 and no counter logic is built.

## Test plan
- N=2, hold=0, start at cycle 0:
  - 8 rd_en in cycles 1–8.
  - a_addr sequence 0,1,0,1,2,3,2,3; b_addr sequence 0,2,1,3,0,2,1,3.
  - res_we in cycles 4,6,8,10 with res_addr 0,1,2,3; done in cycle 11.
- N=3 with hold high for cycles 5–7: identical address/strobe sequence shifted by 3 after cycle 4; done in cycle 33.
- size=0, then size=9 with MAX_N=8: each gives done+size_err in cycle 1, with zero rd_en and zero res_we.
- rst asserted in cycle 5 of an N=4 run: all outputs 0 from cycle 6. A new start in cycle 8 runs to a normal done.
- start pulsed again during RUN: ignored; exactly N² res_we and one done.
- With MATMUL_SEQ_PERF_EN, N=2 plus 2 hold cycles: cycle_count reads 13 after done and stays 13.
